// File: rtl/pipe_pkg.sv
// Shared definitions for all pipeline register stages: occupancy-coded state
// encoding and default payload/control widths.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_WIDTH = 32;
    localparam int unsigned PIPE_CTRL_WIDTH = 8;

    // Encoding equals the number of held entries, so state doubles as occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter advanced by a small increment (0..3) each clock.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + {{(WIDTH-1){1'b0}}, inc};
        count_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry pipeline register stage (main + skid) with registered in_ready,
// flush with drop accounting, and bubble-zeroed control output.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = PIPE_CTRL_WIDTH,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    stage_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic                  in_ready_q, in_ready_d;
    logic                  in_xfer, out_xfer;
    logic [1:0]            drop_inc;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_ONE;
                ST_ONE: begin
                    if (in_xfer && !out_xfer)      state_d = ST_FULL;
                    else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
                end
                ST_FULL:  if (out_xfer) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid  = (state_q != ST_EMPTY);
        occupancy  = state_q;
        in_ready_d = (state_d != ST_FULL);
        // Entries delivered in the flush cycle are not drops; in_xfer and a
        // non-empty head cannot both be zero when out_xfer is set.
        drop_inc   = flush ? (occupancy - {1'b0, out_xfer} + {1'b0, in_xfer}) : 2'd0;
    end

    always_comb begin
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_xfer) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end
                end
                ST_FULL: if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    assign in_ready = in_ready_q;
    assign out_data = main_data_q;
    assign out_ctrl = out_valid ? main_ctrl_q : '0;

endmodule

// File: tb/tb_pipe_stage.sv
// Scenario bench for pipe_stage: queue scoreboard in a negedge monitor plus
// directed tasks for reset, backpressure, flush and counter saturation.
module tb_pipe_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  ctrl;
    } entry_t;

    entry_t      exp_q[$];
    entry_t      e;
    int unsigned checks    = 0;
    int unsigned errors    = 0;
    int unsigned delivered = 0;
    int unsigned dbase;
    int unsigned tmp;
    logic [7:0]  model_drop = 8'd0;
    logic        ox, ix;

    pipe_stage #(
        .DATA_WIDTH (32),
        .CTRL_WIDTH (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs change at posedge+1, so at negedge they show the upcoming transfer.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            model_drop = 8'd0;
        end else begin
            checks++;
            if (occupancy !== 2'(exp_q.size())) begin
                errors++;
                $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, exp_q.size());
            end
            checks++;
            if (drop_cnt !== model_drop) begin
                errors++;
                $display("FAIL sb_drop_cnt: got %0d expected %0d", drop_cnt, model_drop);
            end
            if (!out_valid) begin
                checks++;
                if (out_ctrl !== 8'h00) begin
                    errors++;
                    $display("FAIL sb_bubble_ctrl: got %h expected 00", out_ctrl);
                end
            end
            ox = out_valid && out_ready;
            ix = in_valid && in_ready;
            if (ox) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output: got %h/%h expected none", out_data, out_ctrl);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_ctrl !== e.ctrl) begin
                        errors++;
                        $display("FAIL sb_output: got %h/%h expected %h/%h",
                                 out_data, out_ctrl, e.data, e.ctrl);
                    end
                    delivered++;
                end
            end
            if (flush) begin
                tmp = int'(model_drop) + exp_q.size() + (ix ? 1 : 0);
                model_drop = (tmp > 255) ? 8'd255 : 8'(tmp);
                exp_q.delete();
            end else if (ix) begin
                exp_q.push_back('{data: in_data, ctrl: in_ctrl});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
    endtask

    task automatic fill_full(input logic [31:0] d0, input logic [31:0] d1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d0;
        in_ctrl   = d0[7:0] | 8'h80;
        tick();
        in_data   = d1;
        in_ctrl   = d1[7:0] | 8'h40;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_ctrl !== 8'h0 || occupancy !== 2'd0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b d=%h c=%h occ=%0d drop=%0d expected all 0",
                     in_ready, out_valid, out_data, out_ctrl, occupancy, drop_cnt);
        end
        reset = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready_early: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_data   = 32'h0000_1234;
        in_ctrl   = 8'h15;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_1234 || out_ctrl !== 8'h15 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL single_latency: got vld=%b d=%h c=%h occ=%0d expected 1/00001234/15/1",
                     out_valid, out_data, out_ctrl, occupancy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL single_drain: got vld=%b occ=%0d expected 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        dbase     = delivered;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        in_ctrl   = 8'h01;
        tick();
        in_data   = 32'hB;
        in_ctrl   = 8'h02;
        tick();
        in_data   = 32'hC;
        in_ctrl   = 8'h03;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            errors++;
            $display("FAIL bp_full: got occ=%0d rdy=%b d=%h expected 2/0/0000000a",
                     occupancy, in_ready, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_data !== 32'hA || out_ctrl !== 8'h01) begin
                errors++;
                $display("FAIL bp_hold: got %h/%h expected 0000000a/01", out_data, out_ctrl);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'hB) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b d=%h expected 1/0000000b", in_ready, out_data);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && occupancy != 2'd0; i++) tick();
        checks++;
        if (delivered !== dbase + 3 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_delivered: got %0d occ=%0d expected %0d occ=0",
                     delivered - dbase, occupancy, 3);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush_full();
        fill_full(32'h1111_0011, 32'h2222_0022);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_ctrl  = 8'hEE;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 ||
            drop_cnt !== 8'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got vld=%b c=%h occ=%0d drop=%0d rdy=%b expected 0/00/0/2/1",
                     out_valid, out_ctrl, occupancy, drop_cnt, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_full_discard: got vld=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush_one();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        in_ctrl   = 8'h0F;
        tick();
        dbase     = delivered;
        in_data   = 32'h66;
        in_ctrl   = 8'hF0;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || drop_cnt !== 8'd3 || delivered !== dbase + 1) begin
            errors++;
            $display("FAIL flush_one: got occ=%0d drop=%0d delivered=%0d expected 0/3/1",
                     occupancy, drop_cnt, delivered - dbase);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && occupancy != 2'd0; i++) tick();
        checks++;
        if (occupancy !== 2'd0 || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_drain: got occ=%0d drop=%0d expected 0/3", occupancy, drop_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        fill_full(32'h7777_0077, 32'h8888_0088);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 ||
            out_ctrl !== 8'h0 || occupancy !== 2'd0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_midop: got rdy=%b vld=%b d=%h c=%h occ=%0d drop=%0d expected all 0",
                     in_ready, out_valid, out_data, out_ctrl, occupancy, drop_cnt);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || drop_cnt !== 8'd0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset_midop_release: got rdy=%b drop=%0d occ=%0d expected 1/0/0",
                     in_ready, drop_cnt, occupancy);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 127; i++) begin
            fill_full(32'(i), 32'(i + 1000));
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        checks++;
        if (drop_cnt !== 8'd254) begin
            errors++;
            $display("FAIL sat_254: got %0d expected 254", drop_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            fill_full(32'hAAAA_0000, 32'hBBBB_0000);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            checks++;
            if (drop_cnt !== 8'd255) begin
                errors++;
                $display("FAIL sat_255: got %0d expected 255", drop_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush_full();
        test_flush_one();
        test_back_to_back();
        test_reset_midop();
        test_saturation();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
